// File: rtl/pe_mac.sv
// Output-stationary MAC processing element: forwards A/B operands, accumulates a dot product
// per run, parks it in a result register and drains it through a load/shift chain. Optional macro: PE_SAT_EN.
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic              a_last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  input  logic              flush_in,
  input  logic              load_in,
  input  logic              shift_in,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              a_last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_vld_out,
  output logic              overrun,
  output logic              sat
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  res_q, res_d;
  logic              res_vld_q, res_vld_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic              psum_vld_q, psum_vld_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_vld_q, a_vld_d, a_last_q, a_last_d, b_vld_q, b_vld_d;

  logic              take;
  logic [PROD_W-1:0] a_ext, b_ext, prod_w;
  logic [ACC_W-1:0]  prod_x, base, sum;

  // Operand extension and product; the low PROD_W bits of the widened multiply are exact
  // for both signed and unsigned operands.
  always_comb begin : product_path
    if (SIGNED) begin
      a_ext  = PROD_W'($signed(a_in));
      b_ext  = PROD_W'($signed(b_in));
      prod_w = a_ext * b_ext;
      prod_x = ACC_W'($signed(prod_w));
    end else begin
      a_ext  = PROD_W'(a_in);
      b_ext  = PROD_W'(b_in);
      prod_w = a_ext * b_ext;
      prod_x = ACC_W'(prod_w);
    end
    // An empty accumulator contributes zero, so IDLE and ACC share one adder.
    base = (state_q == ST_ACC) ? acc_q : '0;
  end

`ifdef PE_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           sum_clamp;
  logic           sat_q, sat_d;

  always_comb begin : sum_path
    sum_clamp = 1'b0;
    if (SIGNED) begin
      sum_w = {base[ACC_W-1], base} + {prod_x[ACC_W-1], prod_x};
      sum   = sum_w[ACC_W-1:0];
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        sum_clamp = 1'b1;
        sum       = {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}};
      end
    end else begin
      sum_w = {1'b0, base} + {1'b0, prod_x};
      sum   = sum_w[ACC_W-1:0];
      if (sum_w[ACC_W]) begin
        sum_clamp = 1'b1;
        sum       = '1;
      end
    end
    sat_d = sat_q | (take & sum_clamp);
  end

  always_ff @(posedge clk) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat = sat_q;
`else
  always_comb begin : sum_path
    sum = base + prod_x;
  end

  assign sat = 1'b0;
`endif

  always_comb begin : next_state
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    res_d      = res_q;
    res_vld_d  = res_vld_q;
    psum_d     = psum_q;
    psum_vld_d = psum_vld_q;
    overrun_d  = overrun_q;
    a_d        = a_in;
    a_vld_d    = a_vld_in;
    a_last_d   = a_last_in;
    b_d        = b_in;
    b_vld_d    = b_vld_in;

    // A flush suppresses any operand pair arriving in the same cycle.
    take = a_vld_in & b_vld_in & ~flush_in;

    if (load_in) begin
      psum_d     = res_q;
      psum_vld_d = res_vld_q;
      res_vld_d  = 1'b0;
    end else if (shift_in) begin
      psum_d     = psum_in;
      psum_vld_d = psum_vld_in;
    end

    if (flush_in) begin
      acc_d   = '0;
      state_d = ST_IDLE;
    end else if (take) begin
      if (a_last_in) begin
        // A load in this cycle already took the old result, so nothing is lost.
        if (res_vld_q && !load_in) overrun_d = 1'b1;
        res_d     = sum;
        res_vld_d = 1'b1;
        acc_d     = '0;
        state_d   = ST_IDLE;
      end else begin
        acc_d   = sum;
        state_d = ST_ACC;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      a_last_q   <= 1'b0;
      b_q        <= '0;
      b_vld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      overrun_q  <= overrun_d;
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
      a_last_q   <= a_last_d;
      b_q        <= b_d;
      b_vld_q    <= b_vld_d;
    end
  end

  assign a_out        = a_q;
  assign a_vld_out    = a_vld_q;
  assign a_last_out   = a_last_q;
  assign b_out        = b_q;
  assign b_vld_out    = b_vld_q;
  assign psum_out     = psum_q;
  assign psum_vld_out = psum_vld_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: three instances (signed 24-bit, signed 16-bit, unsigned 24-bit) share stimulus
// and are compared against an integer-arithmetic model of dot-product runs and the drain chain.
module tb_pe_mac;

`ifdef PE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;
  logic        a_vld_in = 0, a_last_in = 0, b_vld_in = 0;
  logic        flush_in = 0, load_in = 0, shift_in = 0, psum_vld_in = 0;
  logic [23:0] psum_in = '0;
  logic [15:0] psum_in_16;

  logic [7:0]  a_out_0, b_out_0, a_out_1, b_out_1, a_out_2, b_out_2;
  logic        a_vld_out_0, a_last_out_0, b_vld_out_0, psum_vld_out_0, overrun_0, sat_0;
  logic        a_vld_out_1, a_last_out_1, b_vld_out_1, psum_vld_out_1, overrun_1, sat_1;
  logic        a_vld_out_2, a_last_out_2, b_vld_out_2, psum_vld_out_2, overrun_2, sat_2;
  logic [23:0] psum_out_0, psum_out_2;
  logic [15:0] psum_out_1;

  int checks = 0;
  int errors = 0;

  assign psum_in_16 = psum_in[15:0];
  always #5 clk = ~clk;

  pe_mac #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1)) dut_s24 (
    .clk(clk), .rstn(rstn), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .flush_in(flush_in), .load_in(load_in), .shift_in(shift_in),
    .psum_in(psum_in), .psum_vld_in(psum_vld_in), .a_out(a_out_0), .a_vld_out(a_vld_out_0),
    .a_last_out(a_last_out_0), .b_out(b_out_0), .b_vld_out(b_vld_out_0), .psum_out(psum_out_0),
    .psum_vld_out(psum_vld_out_0), .overrun(overrun_0), .sat(sat_0));

  pe_mac #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_s16 (
    .clk(clk), .rstn(rstn), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .flush_in(flush_in), .load_in(load_in), .shift_in(shift_in),
    .psum_in(psum_in_16), .psum_vld_in(psum_vld_in), .a_out(a_out_1), .a_vld_out(a_vld_out_1),
    .a_last_out(a_last_out_1), .b_out(b_out_1), .b_vld_out(b_vld_out_1), .psum_out(psum_out_1),
    .psum_vld_out(psum_vld_out_1), .overrun(overrun_1), .sat(sat_1));

  pe_mac #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b0)) dut_u24 (
    .clk(clk), .rstn(rstn), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .flush_in(flush_in), .load_in(load_in), .shift_in(shift_in),
    .psum_in(psum_in), .psum_vld_in(psum_vld_in), .a_out(a_out_2), .a_vld_out(a_vld_out_2),
    .a_last_out(a_last_out_2), .b_out(b_out_2), .b_vld_out(b_vld_out_2), .psum_out(psum_out_2),
    .psum_vld_out(psum_vld_out_2), .overrun(overrun_2), .sat(sat_2));

  // Reference model: exact integer run sums, wrapped or clamped to each instance's width.
  int      acc_w [3] = '{24, 16, 24};
  bit      sgn   [3] = '{1'b1, 1'b1, 1'b0};
  longint  m_run [3], m_res [3], m_psum [3];
  bit      m_inrun [3], m_rvld [3], m_pvld [3], m_ovr [3], m_sat [3];
  logic [7:0] m_a = '0, m_b = '0;
  bit      m_av = 0, m_al = 0, m_bv = 0;

  function automatic longint mask(int w);
    return (64'sd1 << w) - 64'sd1;
  endfunction

  function automatic longint opval(logic [7:0] x, bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic longint wrap(longint v, int w, bit s);
    longint r;
    r = v & mask(w);
    if (s && r >= (64'sd1 << (w - 1))) r = r - (64'sd1 << w);
    return r;
  endfunction

  task automatic model_step();
    longint p, s, lo, hi, old_res;
    bit     old_rvld;
    for (int i = 0; i < 3; i++) begin
      if (!rstn) begin
        m_run[i] = 0; m_res[i] = 0; m_psum[i] = 0;
        m_inrun[i] = 0; m_rvld[i] = 0; m_pvld[i] = 0; m_ovr[i] = 0; m_sat[i] = 0;
      end else begin
        old_res  = m_res[i];
        old_rvld = m_rvld[i];
        if (load_in) begin
          m_psum[i] = old_res & mask(acc_w[i]); m_pvld[i] = old_rvld; m_rvld[i] = 0;
        end else if (shift_in) begin
          m_psum[i] = longint'(psum_in) & mask(acc_w[i]); m_pvld[i] = psum_vld_in;
        end
        if (flush_in) begin
          m_run[i] = 0; m_inrun[i] = 0;
        end else if (a_vld_in && b_vld_in) begin
          p = opval(a_in, sgn[i]) * opval(b_in, sgn[i]);
          s = (m_inrun[i] ? m_run[i] : 64'sd0) + p;
          if (SAT_EN) begin
            lo = sgn[i] ? -(64'sd1 << (acc_w[i] - 1)) : 64'sd0;
            hi = sgn[i] ? (64'sd1 << (acc_w[i] - 1)) - 1 : mask(acc_w[i]);
            if (s > hi) begin s = hi; m_sat[i] = 1; end
            else if (s < lo) begin s = lo; m_sat[i] = 1; end
          end else begin
            s = wrap(s, acc_w[i], sgn[i]);
          end
          if (a_last_in) begin
            if (old_rvld && !load_in) m_ovr[i] = 1;
            m_res[i] = s; m_rvld[i] = 1; m_inrun[i] = 0;
          end else begin
            m_run[i] = s; m_inrun[i] = 1;
          end
        end
      end
    end
    if (!rstn) begin
      m_a = '0; m_b = '0; m_av = 0; m_al = 0; m_bv = 0;
    end else begin
      m_a = a_in; m_b = b_in; m_av = a_vld_in; m_al = a_last_in; m_bv = b_vld_in;
    end
  endtask

  function automatic logic [45:0] pack(logic [23:0] p, logic pv, logic ov, logic st,
                                       logic av, logic al, logic bv, logic [7:0] a, logic [7:0] b);
    return {p, pv, ov, st, av, al, bv, a, b};
  endfunction

  function automatic logic [45:0] obs_word(int i);
    case (i)
      0: return pack(psum_out_0, psum_vld_out_0, overrun_0, sat_0, a_vld_out_0, a_last_out_0, b_vld_out_0, a_out_0, b_out_0);
      1: return pack({8'h00, psum_out_1}, psum_vld_out_1, overrun_1, sat_1, a_vld_out_1, a_last_out_1, b_vld_out_1, a_out_1, b_out_1);
      default: return pack(psum_out_2, psum_vld_out_2, overrun_2, sat_2, a_vld_out_2, a_last_out_2, b_vld_out_2, a_out_2, b_out_2);
    endcase
  endfunction

  function automatic logic [45:0] exp_word(int i);
    return pack(24'(m_psum[i]), m_pvld[i], m_ovr[i], m_sat[i], m_av, m_al, m_bv, m_a, m_b);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    a_vld_in = 0; b_vld_in = 0; a_last_in = 0; flush_in = 0; load_in = 0; shift_in = 0; psum_vld_in = 0;
  endtask

  task automatic fire(logic [7:0] a, logic [7:0] b, logic last);
    idle_in();
    a_in = a; b_in = b; a_vld_in = 1; b_vld_in = 1; a_last_in = last;
  endtask

  task automatic do_reset();
    idle_in(); rstn = 0; cycle(); rstn = 1;
  endtask

  task automatic do_load();
    idle_in(); load_in = 1; cycle(); load_in = 0;
  endtask

  task automatic test_reset();
    a_in = 8'hA5; b_in = 8'h5A; a_vld_in = 1; b_vld_in = 1; load_in = 1;
    rstn = 0; cycle(); rstn = 1; idle_in();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_word(i) !== 46'h0) begin
        errors++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs_word(i));
      end
    end
  endtask

  task automatic test_basic_dot();
    fire(8'd3, 8'd4, 0); cycle();
    checks++; if (a_out_0 !== 8'd3 || b_out_0 !== 8'd4 || a_vld_out_0 !== 1'b1 || a_last_out_0 !== 1'b0) begin
      errors++; $display("FAIL basic_fwd1: got a=%h b=%h av=%b al=%b want 03 04 1 0", a_out_0, b_out_0, a_vld_out_0, a_last_out_0);
    end
    fire(8'hFE, 8'd5, 1); cycle();
    checks++; if (a_out_0 !== 8'hFE || b_out_0 !== 8'd5 || a_last_out_0 !== 1'b1) begin
      errors++; $display("FAIL basic_fwd2: got a=%h b=%h al=%b want fe 05 1", a_out_0, b_out_0, a_last_out_0);
    end
    do_load();
    checks++; if (psum_out_0 !== 24'd2 || psum_vld_out_0 !== 1'b1) begin
      errors++; $display("FAIL basic_psum: got %h vld=%b want 000002 1", psum_out_0, psum_vld_out_0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    fire(8'd7, 8'd7, 1); cycle();
    fire(8'd1, 8'd1, 1); cycle(); idle_in(); cycle();
    checks++; if (overrun_0 !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b want 1", overrun_0);
    end
    do_load();
    checks++; if (psum_out_0 !== 24'd1) begin
      errors++; $display("FAIL overrun_psum: got %h want 000001", psum_out_0);
    end
    do_reset();
    fire(8'd7, 8'd7, 1); cycle();
    fire(8'd1, 8'd1, 1); load_in = 1; cycle();
    checks++; if (psum_out_0 !== 24'd49 || overrun_0 !== 1'b0) begin
      errors++; $display("FAIL load_fire_same: got psum=%h ovr=%b want 000031 0", psum_out_0, overrun_0);
    end
    do_load();
    checks++; if (psum_out_0 !== 24'd1 || psum_vld_out_0 !== 1'b1) begin
      errors++; $display("FAIL load_fire_resvld: got psum=%h vld=%b want 000001 1", psum_out_0, psum_vld_out_0);
    end
    do_load();
    checks++; if (psum_vld_out_0 !== 1'b0) begin
      errors++; $display("FAIL resvld_cleared: got %b want 0", psum_vld_out_0);
    end
  endtask

  task automatic test_flush_gaps();
    fire(8'd10, 8'd10, 0); cycle();
    idle_in(); a_vld_in = 1; a_in = 8'd50; cycle();
    idle_in(); flush_in = 1; cycle();
    fire(8'd2, 8'd3, 1); cycle();
    do_load();
    checks++; if (psum_out_0 !== 24'd6) begin
      errors++; $display("FAIL flush_gap_result: got %h want 000006", psum_out_0);
    end
    fire(8'd5, 8'd5, 0); cycle();
    fire(8'd9, 8'd9, 0); flush_in = 1; cycle();
    idle_in(); a_last_in = 1; a_vld_in = 1; cycle();
    fire(8'd1, 8'd2, 1); cycle();
    do_load();
    checks++; if (psum_out_0 !== 24'd2) begin
      errors++; $display("FAIL flush_with_fire: got %h want 000002", psum_out_0);
    end
  endtask

  task automatic test_drain_chain();
    fire(8'd4, 8'd5, 1); cycle();
    idle_in(); psum_in = 24'h123456; psum_vld_in = 1; load_in = 1; shift_in = 1; cycle();
    checks++; if (psum_out_0 !== 24'd20 || psum_vld_out_0 !== 1'b1) begin
      errors++; $display("FAIL drain_load_wins: got %h vld=%b want 000014 1", psum_out_0, psum_vld_out_0);
    end
    load_in = 0; cycle();
    checks++; if (psum_out_0 !== 24'h123456 || psum_vld_out_0 !== 1'b1) begin
      errors++; $display("FAIL drain_shift: got %h vld=%b want 123456 1", psum_out_0, psum_vld_out_0);
    end
    shift_in = 0; psum_in = 24'h0ABCDE; psum_vld_in = 0; cycle();
    checks++; if (psum_out_0 !== 24'h123456 || psum_vld_out_0 !== 1'b1) begin
      errors++; $display("FAIL drain_hold: got %h vld=%b want 123456 1", psum_out_0, psum_vld_out_0);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] want16;
    do_reset();
    for (int k = 0; k < 3; k++) begin fire(8'd127, 8'd127, 0); cycle(); end
    fire(8'd127, 8'd127, 1); cycle();
    do_load();
    want16 = SAT_EN ? 16'h7FFF : 16'hFC04;
    checks++; if (psum_out_1 !== want16 || sat_1 !== SAT_EN) begin
      errors++; $display("FAIL sat_acc16: got %h sat=%b want %h %b", psum_out_1, sat_1, want16, SAT_EN);
    end
    checks++; if (psum_out_0 !== 24'h00FC04 || sat_0 !== 1'b0) begin
      errors++; $display("FAIL sat_acc24: got %h sat=%b want 00fc04 0", psum_out_0, sat_0);
    end
  endtask

  task automatic test_reset_mid_run();
    fire(8'd1, 8'd1, 1); cycle();
    fire(8'd2, 8'd2, 0); cycle();
    fire(8'd5, 8'd5, 0); load_in = 1; shift_in = 1; psum_vld_in = 1; rstn = 0; cycle(); rstn = 1; idle_in();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_word(i) !== 46'h0) begin
        errors++; $display("FAIL midrun_reset[%0d]: got %h want 0", i, obs_word(i));
      end
    end
    do_load();
    checks++; if (psum_vld_out_0 !== 1'b0 || psum_out_0 !== 24'd0) begin
      errors++; $display("FAIL midrun_discard: got %h vld=%b want 000000 0", psum_out_0, psum_vld_out_0);
    end
    fire(8'hFD, 8'hFD, 1); cycle();
    do_load();
    checks++; if (psum_out_0 !== 24'd9 || psum_out_2 !== 24'd64009) begin
      errors++; $display("FAIL midrun_after: got s=%h u=%h want 000009 00fa09", psum_out_0, psum_out_2);
    end
    fire(8'hFF, 8'hFF, 1); cycle();
    do_load();
    checks++; if (psum_out_2 !== 24'd65025 || psum_out_0 !== 24'd1) begin
      errors++; $display("FAIL unsigned_max: got u=%h s=%h want 00fe01 000001", psum_out_2, psum_out_0);
    end
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(3))
      0: return 8'h7F;
      1: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      a_in = rand_op(); b_in = rand_op();
      a_vld_in = ($urandom_range(3) != 0); b_vld_in = ($urandom_range(3) != 0);
      a_last_in = ($urandom_range(3) == 0); flush_in = ($urandom_range(19) == 0);
      load_in = ($urandom_range(4) == 0); shift_in = ($urandom_range(4) == 0);
      psum_in = 24'($urandom); psum_vld_in = 1'($urandom);
      rstn = ($urandom_range(99) != 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errors++; $display("FAIL random[%0d] cyc %0d: got %h want %h", i, n, obs_word(i), exp_word(i));
        end
      end
    end
    rstn = 1; idle_in();
  endtask

  initial begin
    idle_in();
    cycle(); cycle();
    test_reset();
    test_basic_dot();
    test_overrun();
    test_flush_gaps();
    test_drain_chain();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised output-stationary multiply-accumulate processing element for the systolic array; the successor to the fixed 8-bit PE. Operands travel right (A) and down (B) with valid/last qualifiers. Each PE accumulates a dot product over a variable-length run terminated by `a_last_in`, then parks the result in a separate result register, so the next run can start immediately. Results leave through a column-wide load/shift drain chain that the array controller drives.

## Interface
Parameters:
- `DATA_W`, 8: operand width.
- `ACC_W`, 24: accumulator and partial-sum width; must be ≥ 2·`DATA_W`.
- `SIGNED`, 1: 1 = two's-complement operands, 0 = unsigned.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  reset, synchronous, active-low.
- `a_in`  in  DATA_W  A operand from left neighbour.
- `a_vld_in`  in  1  A valid.
- `a_last_in`  in  1  marks the final operand pair of a dot product.
- `b_in`  in  DATA_W  B operand from upper neighbour.
- `b_vld_in`  in  1  B valid.
- `flush_in`  in  1  abort the current run; clear the accumulator.
- `load_in`  in  1  drain: copy the result register into `psum_out`.
- `shift_in`  in  1  drain: copy `psum_in` into `psum_out`.
- `psum_in`  in  ACC_W  drain chain from the PE above.
- `psum_vld_in`  in  1  valid for `psum_in`.
- `a_out`, `a_vld_out`, `a_last_out`  out  DATA_W/1/1  registered A forward.
- `b_out`, `b_vld_out`  out  DATA_W/1  registered B forward.
- `psum_out`  out  ACC_W  drain chain to the PE below.
- `psum_vld_out`  out  1  valid for `psum_out`.
- `overrun`  out  1  sticky: an unread result was overwritten.
- `sat`  out  1  sticky: saturation occurred (only with `PE_SAT_EN`).

## Operation
- `fire = a_vld_in & b_vld_in`. If only one of the two valids is high, nothing is accumulated.
- Product: `a_in*b_in`, 2·`DATA_W` bits, signed or unsigned per `SIGNED`. It is sign- or zero-extended to `ACC_W`. Sums wrap modulo 2^ACC_W unless `PE_SAT_EN` is defined.
- FSM states:
  - IDLE (accumulator empty), on `fire`:
    - if `a_last_in`: `res <= prod`, `res_vld <= 1`, stay in IDLE.
    - else: `acc <= prod`, go to ACC.
  - ACC, on `fire`:
    - if `a_last_in`: `res <= acc + prod`, `res_vld <= 1`, go to IDLE.
    - else: `acc <= acc + prod`.
- `a_last_in` without `fire` is ignored, but it is still forwarded.
- `flush_in`: `acc <= 0`, state IDLE. It overrides any `fire` in the same cycle. `res` and `res_vld` are untouched.
- Overrun: a last-fire while `res_vld == 1` and `load_in == 0` sets `overrun`; the new result overwrites `res`.
- Drain chain (`psum_out` and `psum_vld_out` are registers):
  - `load_in`: `psum_out <= res`, `psum_vld_out <= res_vld`, `res_vld <= 0`.
  - `shift_in` (without `load_in`): `psum_out <= psum_in`, `psum_vld_out <= psum_vld_in`.
  - If both are high, `load_in` wins.
  - If neither is high, `psum_out` and `psum_vld_out` hold their values.
- Load and a last-fire in the same cycle:
  - the load takes the old `res` and `res_vld`;
  - the new result is stored and `res_vld` ends at 1;
  - `overrun` is not set.
- Forward path: `a_*_out` and `b_*_out` are the inputs delayed by one register, every cycle, regardless of FSM state.

## Timing
- Reset (`rstn == 0` at a posedge): all outputs, `acc`, `res` and `res_vld` go to 0, and the FSM goes to IDLE. Reset applied mid-run discards the partial sum and any pending result.
- Forward latency: 1 cycle.
- Result latency: a last-fire at edge t makes `res_vld` 1 after edge t. `load_in` at edge t+1 or later presents `psum_vld_out` after that edge.
- Drain of an N-deep column takes one load cycle plus N−1 shift cycles. The bottom PE presents row N−1 first.
- Back-to-back runs are supported with zero bubble: `fire` with `a_last_in` is allowed every cycle.

## Configuration
- `PE_SAT_EN` defined:
  - accumulation and last-sums clamp to the `ACC_W` range: signed [−2^(ACC_W−1), 2^(ACC_W−1)−1] or unsigned [0, 2^ACC_W−1];
  - any clamp sets `sat`;
  - `sat` is sticky until `rstn`.
- `PE_SAT_EN` undefined: sums wrap modulo 2^ACC_W and `sat` is tied to 0.

## Test plan
All scenarios use `DATA_W=8`, `ACC_W=24`, `SIGNED=1` unless stated.
- Basic dot product: fire (3,4), then fire (−2,5) with last → `res_vld=1`; load → `psum_out=2`, `psum_vld_out=1` one cycle later; `a_out`/`b_out` echo each operand one cycle after it is applied.
- Single-element run and overrun: fire (7,7) with last, then fire (1,1) with last, no load → `overrun=1`; load → `psum_out=1`. Repeat with load in the same cycle as the second last-fire → `psum_out=49`, `overrun=0`, `res_vld` stays 1.
- Flush and gaps: fire (10,10), cycle with `a_vld_in=1` and `b_vld_in=0`, flush, fire (2,3) with last → result 6. A flush in the same cycle as a fire discards that product.
- Drain chain: with `psum_in=0x123456`, `psum_vld_in=1`, assert load and shift together → `psum_out=res`; shift alone → `psum_out=0x123456`.
- Saturation (`PE_SAT_EN`, `ACC_W=16`): 3× fire (127,127), then fire (127,127) with last → `res=32767`, `sat=1`. Without the macro → `res=64516 mod 65536` (−1020 signed), `sat=0`.
- Reset mid-run: assert `rstn=0` while in ACC with `res_vld=1` → next cycle all outputs 0, a subsequent single last-fire (−3,−3) gives 9. `SIGNED=0`: fire (255,255) with last gives 65025.
